// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with serial taps at both ends. A saturating shift counter and a one-cycle
// done pulse report when a full word has been shifted since the last load or
// reset. There is no handshake here: each enabled edge applies the requested
// mode unconditionally. The only state is the data word, the counter and the
// done flop, all of which appear directly on the outputs.
module univ_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           parallel_in,
  input  logic                       serial_in_msb,
  input  logic                       serial_in_lsb,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       serial_out_lsb,
  output logic                       serial_out_msb,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       shift_done
);

  localparam int CW = $clog2(WIDTH + 1);

  // Counter saturation point, and the value one step before it
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shifting;

  // Next-state for data, counter and done pulse; done defaults low every edge
  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHR: begin
          data_d   = {serial_in_msb, data_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_SHL: begin
          data_d   = {data_q[WIDTH-2:0], serial_in_lsb};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          data_d = parallel_in;
          cnt_d  = '0;
        end
        MODE_HOLD: begin
          data_d = data_q;
        end
        default: begin
          data_d = data_q;
        end
      endcase
    end
    // Both shift directions advance the same counter; it sticks at WIDTH and
    // the pulse fires only on the WIDTH-1 -> WIDTH transition.
    if (shifting && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset overriding en and mode
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Outputs: registered word/count/pulse, serial taps are plain wires
  always_comb begin
    parallel_out   = data_q;
    serial_out_lsb = data_q[0];
    serial_out_msb = data_q[WIDTH-1];
    shift_cnt      = cnt_q;
    shift_done     = done_q;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4, RESET_VAL=0.
module tb_univ_shift_reg;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  // Clock / reset block
  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in_msb;
  logic             serial_in_lsb;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_lsb;
  logic             serial_out_msb;
  logic [CW-1:0]    shift_cnt;
  logic             shift_done;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .mode          (mode),
    .parallel_in   (parallel_in),
    .serial_in_msb (serial_in_msb),
    .serial_in_lsb (serial_in_lsb),
    .parallel_out  (parallel_out),
    .serial_out_lsb(serial_out_lsb),
    .serial_out_msb(serial_out_msb),
    .shift_cnt     (shift_cnt),
    .shift_done    (shift_done)
  );

  // Scoreboard state
  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output check; serial tap expectations come from the expected word
  task automatic check_all(input string tag, input logic [WIDTH-1:0] e_po,
                           input int e_cnt, input logic e_done);
    check({tag, "_po"},   32'(parallel_out),   32'(e_po));
    check({tag, "_cnt"},  32'(shift_cnt),      32'(e_cnt));
    check({tag, "_done"}, 32'(shift_done),     32'(e_done));
    check({tag, "_slsb"}, 32'(serial_out_lsb), 32'(e_po[0]));
    check({tag, "_smsb"}, 32'(serial_out_msb), 32'(e_po[WIDTH-1]));
  endtask

  // Driver tasks: advance one edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] val);
    en = 1'b1; mode = 2'b11; parallel_in = val;
    step();
  endtask

  task automatic do_shift(input logic [1:0] m, input logic sbit);
    en = 1'b1; mode = m;
    serial_in_msb = sbit; serial_in_lsb = sbit;
    step();
  endtask

  initial begin
    logic [WIDTH-1:0] e;
    reset = 1'b1; en = 1'($urandom_range(0, 1)); mode = 2'($urandom_range(0, 3));
    parallel_in = 4'b1111; serial_in_msb = 1'b1; serial_in_lsb = 1'b1;

    // 1. Reset for two edges with random controls, then hold
    step();
    check_all("rst1", 4'b0000, 0, 1'b0);
    en = 1'($urandom_range(0, 1)); mode = 2'($urandom_range(0, 3));
    step();
    check_all("rst2", 4'b0000, 0, 1'b0);
    reset = 1'b0; en = 1'b1; mode = 2'b00;
    step();
    check_all("hold_after_rst", 4'b0000, 0, 1'b0);

    // 2. Parallel load
    do_load(4'b1010);
    check_all("load_1010", 4'b1010, 0, 1'b0);

    // 3. Shift right with msb=1, pulse on 4th, saturate on 5th
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b1111);
    for (int i = 1; i <= 4; i++) begin
      do_shift(2'b01, 1'b1);
      e = exp_q.pop_front();
      check_all($sformatf("shr%0d", i), e, i, (i == 4));
    end
    do_shift(2'b01, 1'b1);
    check_all("shr_sat", 4'b1111, 4, 1'b0);

    // 4. Shift left, then reload mid-sequence restarts the count
    do_load(4'b1010);
    check_all("reload", 4'b1010, 0, 1'b0);
    do_shift(2'b10, 1'b0);
    check_all("shl1", 4'b0100, 1, 1'b0);
    do_shift(2'b10, 1'b0);
    check_all("shl2", 4'b1000, 2, 1'b0);
    do_shift(2'b10, 1'b0);
    check_all("shl3", 4'b0000, 3, 1'b0);
    do_load(4'b0110);
    check_all("load_mid", 4'b0110, 0, 1'b0);
    do_shift(2'b10, 1'b1);
    check_all("shl_b1", 4'b1101, 1, 1'b0);
    do_shift(2'b10, 1'b1);
    check_all("shl_b2", 4'b1011, 2, 1'b0);
    do_shift(2'b10, 1'b1);
    check_all("shl_b3", 4'b0111, 3, 1'b0);
    do_shift(2'b10, 1'b1);
    check_all("shl_b4", 4'b1111, 4, 1'b1);
    en = 1'b1; mode = 2'b00;
    step();
    check_all("hold_sat", 4'b1111, 4, 1'b0);

    // Mixed directions share one counter
    do_load(4'b1010);
    do_shift(2'b01, 1'b0);
    check_all("mix1", 4'b0101, 1, 1'b0);
    do_shift(2'b10, 1'b1);
    check_all("mix2", 4'b1011, 2, 1'b0);
    do_shift(2'b01, 1'b0);
    check_all("mix3", 4'b0101, 3, 1'b0);
    do_shift(2'b10, 1'b0);
    check_all("mix4", 4'b1010, 4, 1'b1);

    // 5. en=0 freezes everything, even with load requested
    do_load(4'b1010);
    do_shift(2'b01, 1'b0);
    do_shift(2'b10, 1'b0);
    check_all("pre_freeze", 4'b1010, 2, 1'b0);
    en = 1'b0; mode = 2'b11; parallel_in = 4'b0110;
    step();
    check_all("freeze_load", 4'b1010, 2, 1'b0);
    do_shift(2'b01, 1'b1);
    en = 1'b0; mode = 2'b01;
    step();
    check_all("freeze_shift", 4'b1101, 3, 1'b0);

    // Reset on the edge that would have reached WIDTH: no pulse
    reset = 1'b1; en = 1'b1; mode = 2'b01;
    step();
    check_all("rst_at_last", 4'b0000, 0, 1'b0);
    reset = 1'b0;

    // 6. Two shifts, reset, then load and shift: exactly one pulse
    do_load(4'b0011);
    do_shift(2'b01, 1'b0);
    do_shift(2'b01, 1'b0);
    check_all("pre_rst", 4'b0000, 2, 1'b0);
    reset = 1'b1; en = 1'b1; mode = 2'b01;
    step();
    check_all("mid_rst", 4'b0000, 0, 1'b0);
    reset = 1'b0;
    do_load(4'b1001);
    check_all("load_1001", 4'b1001, 0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      do_shift(2'b01, 1'b0);
      if (shift_done === 1'b1) pulses++;
    end
    check_all("post_seq", 4'b0000, 4, 1'b0);
    check("pulse_count", 32'(pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
